// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multiplier_8x8 between
// NUM_REQ requesters; one operation in flight, timeout-protected.
// Ports: clk, reset_a (sync, active-high); req/req_dataa/req_datab from
//   clients; gnt/rsp_valid/rsp_product/rsp_err/busy back to clients;
//   mult_start/mult_dataa/mult_datab/mult_done/mult_product to the multiplier.
// Option: define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests
//   directly (IDLE -> RESP) without using the multiplier.
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                   clk,
    input  logic                   reset_a,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_dataa,
    input  logic [8*NUM_REQ-1:0]   req_datab,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_product,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mult_start,
    output logic [7:0]             mult_dataa,
    output logic [7:0]             mult_datab,
    input  logic                   mult_done,
    input  logic [15:0]            mult_product
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [NUM_REQ-1:0] ONE = 1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   wait_cnt;

    logic            sel_hit;
    logic [IW-1:0]   sel_idx;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    int              j;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!sel_hit && req[j]) begin
                sel_hit = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    assign sel_a = req_dataa[sel_idx*8 +: 8];
    assign sel_b = req_datab[sel_idx*8 +: 8];

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            mult_start  <= 1'b0;
        end else begin
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            mult_start  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_hit) begin
                        idx        <= sel_idx;
                        mult_dataa <= sel_a;
                        mult_datab <= sel_b;
                        busy       <= 1'b1;
                        gnt        <= ONE << sel_idx;
                        if (BYPASS && (sel_a == 8'd0 || sel_b == 8'd0)) begin
                            rsp_valid <= ONE << sel_idx;
                            state     <= RESP;
                        end else begin
                            mult_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // done at count 0 may be left over from the last operation
                    if (wait_cnt != '0 && mult_done) begin
                        rsp_valid   <= ONE << idx;
                        rsp_product <= mult_product;
                        state       <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= ONE << idx;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: random requesters and a behavioural multiplier
// against a transaction-level round-robin reference model.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int TO = 32;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_a;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_dataa;
    logic [8*N-1:0] req_datab;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_product;
    logic           rsp_err;
    logic           busy;
    logic           mult_start;
    logic [7:0]     mult_dataa;
    logic [7:0]     mult_datab;
    logic           mult_done;
    logic [15:0]    mult_product;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .req          (req),
        .req_dataa    (req_dataa),
        .req_datab    (req_datab),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_done    (mult_done),
        .mult_product (mult_product)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rnd_op();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return 8'd0;
        if (s == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    // reference model: one transaction at a time
    bit          op_active;
    int          op_start;
    int          op_end;
    int          w;
    int          ptr;
    bit          byp;
    logic [15:0] exp_prod;
    bit          exp_err;
    logic [7:0]  ea, eb;

    // requesters and multiplier behaviour
    bit          rq[N];
    logic [7:0]  ra[N], rb[N];
    int          cd;
    bit          never_m;
    bit          force_rst;
    bit          force_req;
    int          n_ops, n_to, n_rst;

    initial begin
        int  k, mode, sel;
        bit  idle_now, rst_next;
        logic [31:0] exp_g, exp_rv;

        reset_a = 1'b1; req = '0; req_dataa = '0; req_datab = '0;
        mult_done = 1'b0; mult_product = '0;
        op_active = 0; op_start = 0; op_end = -1; w = 0; ptr = 0;
        byp = 0; exp_prod = '0; exp_err = 0; ea = '0; eb = '0;
        cd = 0; never_m = 0; force_rst = 0; force_req = 0;
        n_ops = 0; n_to = 0; n_rst = 0;
        for (int i = 0; i < N; i++) begin
            rq[i] = 0; ra[i] = '0; rb[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);

        for (int c = 0; c < 6000; c++) begin
            // expected outputs in this cycle
            exp_g  = (op_active && c == op_start) ? (32'd1 << w) : 32'd0;
            exp_rv = (op_active && c == op_end) ? (32'd1 << w) : 32'd0;
            chk("gnt", 32'(gnt), exp_g);
            chk("mult_start", 32'(mult_start),
                32'(op_active && c == op_start && !byp));
            chk("busy", 32'(busy), 32'(op_active));
            chk("rsp_valid", 32'(rsp_valid), exp_rv);
            chk("rsp_product", 32'(rsp_product),
                (exp_rv != 0) ? 32'(exp_prod) : 32'd0);
            chk("rsp_err", 32'(rsp_err), (exp_rv != 0) ? 32'(exp_err) : 32'd0);
            chk("mult_dataa", 32'(mult_dataa), 32'(ea));
            chk("mult_datab", 32'(mult_datab), 32'(eb));

            // multiplier behaviour for the next edge
            if (mult_start) begin
                mode = $urandom_range(0, 9);
                never_m = (mode <= 1);
                if (mode == 1) mult_done = 1'b1;
                if (mode == 2) cd = $urandom_range(TO - 3, TO + 1);
                else cd = $urandom_range(1, 8);
            end else begin
                if (cd > 0) cd--;
                mult_done = (cd == 0) && !never_m;
            end
            mult_product = 16'(mult_dataa) * 16'(mult_datab);

            // model progress
            idle_now = !op_active;
            rst_next = 0;
            if (c == 3000) force_rst = 1;
            if (op_active && c == op_end) begin
                op_active = 0;
                ptr = (w + 1) % N;
                n_ops++;
                if (exp_err) n_to++;
            end else if (op_active && op_end < 0 && c > op_start) begin
                k = c - op_start - 1;
                if ((force_rst && k == 2) || $urandom_range(0, 399) == 0) begin
                    rst_next = 1;
                    force_req = force_rst;
                    force_rst = 0;
                    n_rst++;
                    op_active = 0; ptr = 0; ea = '0; eb = '0;
                end else if (k >= 1 && mult_done) begin
                    op_end = c + 1;
                    exp_prod = 16'(ea) * 16'(eb);
                    exp_err = 0;
                end else if (k == TO - 1) begin
                    op_end = c + 1;
                    exp_prod = '0;
                    exp_err = 1;
                end
            end
            reset_a = rst_next;

            // requester behaviour
            if (exp_g != 0) begin
                if ($urandom_range(0, 1) == 0) rq[w] = 0;
                else begin ra[w] = rnd_op(); rb[w] = rnd_op(); end
            end
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1; ra[i] = rnd_op(); rb[i] = rnd_op();
                end
            end
            if (idle_now && force_req) begin
                force_req = 0;
                for (int i = 0; i < N; i++) rq[i] = (i == 0 || i == 3);
            end

            // arbitration decision for the next edge
            if (idle_now) begin
                sel = -1;
                for (int i = 0; i < N; i++)
                    if (sel < 0 && rq[(ptr + i) % N]) sel = (ptr + i) % N;
                if (sel >= 0) begin
                    op_active = 1; op_start = c + 1; w = sel;
                    ea = ra[sel]; eb = rb[sel];
                    byp = BYP && (ea == 0 || eb == 0);
                    op_end = byp ? c + 1 : -1;
                    exp_prod = '0; exp_err = 0;
                end
            end

            for (int i = 0; i < N; i++) begin
                req[i] = rq[i];
                req_dataa[8*i +: 8] = ra[i];
                req_datab[8*i +: 8] = rb[i];
            end
            @(negedge clk);
        end

        chk("ops_done", 32'(n_ops > 50), 32'd1);
        chk("timeouts_seen", 32'(n_to > 0), 32'd1);
        chk("resets_seen", 32'(n_rst > 0), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
